// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared FSM state encoding and default FIFO depth for the UART TX scheduler.
package uart_sched_pkg;
    localparam int DEFAULT_DEPTH = 8;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; storage is unreset, only pointers and count are.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    // DEPTH is a power of two, so plain pointer increment wraps at DEPTH-1 -> 0
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: buffers M-stage UART store bytes and launches them one at a time into the transmitter.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     stall,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     idle
);
    state_e     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d, head;
    logic       full, empty, push, pop;
    // A full FIFO refuses the store even if a pop happens this cycle
    assign stall    = wr_valid & full;
    assign push     = wr_valid & ~full;
    assign tx_start = state_q == LAUNCH;
    assign tx_data  = tx_data_q;
    assign idle     = empty & (state_q == IDLE);
    sync_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_data),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: if (!empty && !tx_busy) begin
                state_d   = LAUNCH;
                tx_data_d = head;
                pop       = 1'b1;
            end
            LAUNCH:    state_d = WAIT_ACK;
            WAIT_ACK:  state_d = tx_busy ? WAIT_DONE : WAIT_ACK;
            WAIT_DONE: state_d = tx_busy ? WAIT_DONE : IDLE;
            default:   state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized and directed scoreboard bench against a queue-based reference model.
module tb_uart_tx_scheduler;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset, wr_valid, tx_busy, stall, tx_start, idle;
    logic [7:0]    wr_data, tx_data;
    logic [CW-1:0] count;
    logic          model_busy = 1'b0, ext_busy = 1'b0, in_flight = 1'b0;
    int            busy_len = 10;
    int            tests = 0, fails = 0;
    int            accepted = 0, starts = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    mon_e;

    assign tx_busy = model_busy | ext_busy;
    always #5 clk = ~clk;

    uart_tx_scheduler #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .stall    (stall),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .count    (count),
        .idle     (idle)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every launch must present the oldest byte still owed
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tx_start", int'(tx_start), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_data", tx_data, mon_e);
                check("busy_low_at_start", tx_busy, 0);
                starts++;
            end
        end
    end

    // Transmitter model: busy rises the cycle after tx_start, lasts busy_len cycles
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            in_flight = 1'b1;
            @(posedge clk);
            #1 model_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 model_busy = 1'b0;
            in_flight = 1'b0;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int   tries = 0;
        logic exp_stall;
        forever begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = b;
            #1;
            exp_stall = (accepted - starts) == DEPTH;
            check("stall", stall, exp_stall);
            check("count", count, accepted - starts);
            if (!exp_stall) begin
                exp_q.push_back(b);
                accepted++;
                break;
            end
            if (++tries > 500) begin
                tests++;
                fails++;
                $display("FAIL push_timeout: byte %0h never accepted", b);
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        @(negedge clk);
        wr_valid = 1'b0;
        #2;
        while ((exp_q.size() != 0 || in_flight) && n < 5000) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout_%s: %0d bytes still queued", tag, exp_q.size());
        end
        repeat (2) @(negedge clk);
        #1;
        check({"idle_", tag}, idle, 1);
        check({"count_", tag}, count, 0);
        check({"sent_", tag}, starts, accepted);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        reset    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_count", count, 0);
        check("rst_idle", idle, 1);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        reset    = 1'b0;
        wr_valid = 1'b0;

        // Single byte and launch latency
        push_byte(8'h41);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check("lat_count_n1", count, 1);
        check("lat_no_start_n1", tx_start, 0);
        @(negedge clk);
        #1;
        check("lat_start_n2", tx_start, 1);
        check("lat_data_n2", tx_data, 8'h41);
        drain("single");

        // Burst "HELLO"
        busy_len = 10;
        foreach (hello[i]) push_byte(hello[i]);
        drain("burst");

        // Full FIFO while transmitter is held busy, then simultaneous push/pop at full
        ext_busy = 1'b1;
        busy_len = 3;
        for (int i = 0; i < DEPTH; i++) push_byte(8'hB0 + 8'(i));
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 8'hB8;
        #1;
        check("full_count", count, DEPTH);
        check("full_stall", stall, 1);
        check("full_blocks_launch", starts, accepted - DEPTH);
        ext_busy = 1'b0;
        push_byte(8'hB8);
        drain("full");

        // Wrap: 20 sequential bytes through the FIFO twice around
        busy_len = 1;
        for (int i = 0; i < 20; i++) push_byte(8'(i));
        drain("wrap");

        // Reset during WAIT_DONE with three bytes still queued
        busy_len = 30;
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
        @(negedge clk);
        wr_valid = 1'b0;
        n = 0;
        while (!tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_busy_seen", tx_busy, 1);
        @(negedge clk);
        #1;
        check("rst_mid_count_before", count, 3);
        reset = 1'b1;
        #1;
        check("rst_mid_count", count, 0);
        check("rst_mid_idle", idle, 1);
        check("rst_mid_tx_start", tx_start, 0);
        check("rst_mid_tx_data", tx_data, 8'h00);
        exp_q.delete();
        accepted = 0;
        starts   = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("rst_mid_quiet", starts, 0);
        check("rst_mid_idle_after", idle, 1);
        push_byte(8'h5A);
        drain("post_reset");

        // Randomized traffic with random gaps and busy lengths
        for (int i = 0; i < 200; i++) begin
            busy_len = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                wr_valid = 1'b0;
                repeat ($urandom_range(0, 15)) @(negedge clk);
            end else begin
                push_byte(8'($urandom));
            end
        end
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
